// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier sequencer.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq_control_iter_counter.sv
// Iteration counter: sync clear, increment enable, flag on the last (sign) iteration.
module iter_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt,
    output logic          o_term
);

    logic [CW-1:0] r_cnt;

    // Saturates at WIDTH so the count reads WIDTH in HOLD and never wraps.
    always_ff @(posedge Clk) begin
        if (Reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CW'(WIDTH))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_control.sv
// Sequencer for the signed shift-add multiplier: CLEAR, then WIDTH add/shift
// iterations with a subtract on the sign bit, then HOLD until Execute drops.
module mult_seq_control
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      LoadA,
    input  logic                      LoadB,
    input  logic                      Execute,
    input  logic                      M,
    output logic                      Ld_A,
    output logic                      Ld_B,
    output logic                      Clr_XA,
    output logic                      Add_En,
    output logic                      Sub_En,
    output logic                      Shift_En,
    output logic                      Busy,
    output logic                      Done,
    output logic [cnt_w(WIDTH)-1:0]   Bit_Cnt
);

    localparam int CW = cnt_w(WIDTH);

    state_t          r_state;
    state_t          w_next;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic            w_term;
    logic [CW-1:0]   w_cnt;

    iter_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_cnt),
        .o_term (w_term)
    );

    assign Bit_Cnt = w_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        Ld_A      = 1'b0;
        Ld_B      = 1'b0;
        Clr_XA    = 1'b0;
        Add_En    = 1'b0;
        Sub_En    = 1'b0;
        Shift_En  = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;

        case (r_state)
            IDLE: begin
                Ld_A = LoadA;
                Ld_B = LoadB;
                if (Execute) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                Clr_XA    = 1'b1;
                Busy      = 1'b1;
                w_cnt_clr = 1'b1;
                w_next    = ADD;
            end
            ADD: begin
                Busy = 1'b1;
                // The sign bit carries negative weight, hence subtract on the last iteration.
                if (w_term) begin
                    Sub_En = M;
                end else begin
                    Add_En = M;
                end
                if (SKIP_ZERO && !M) begin
                    Shift_En  = 1'b1;
                    w_cnt_inc = 1'b1;
                    w_next    = w_term ? HOLD : ADD;
                end else begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                Shift_En  = 1'b1;
                Busy      = 1'b1;
                w_cnt_inc = 1'b1;
                w_next    = w_term ? HOLD : ADD;
            end
            HOLD: begin
                Done = 1'b1;
                if (!Execute) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_control.sv
// Directed bench for mult_seq_control: three configurations driven with a
// modelled B register whose LSB feeds M and shifts whenever Shift_En is seen.
module tb_mult_seq_control;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [2:0] rst, exe, lda, ldb, m;
    logic [2:0] ld_a, ld_b, clr, add, sub, shf, busy, done;
    logic [3:0] bc0, bc1;
    logic [4:0] bc2;

    int errors = 0;
    int checks = 0;
    logic [31:0] b;
    int cur;

    mult_seq_control #(.WIDTH(8), .SKIP_ZERO(1'b0)) u0 (
        .Clk(Clk), .Reset(rst[0]), .LoadA(lda[0]), .LoadB(ldb[0]), .Execute(exe[0]), .M(m[0]),
        .Ld_A(ld_a[0]), .Ld_B(ld_b[0]), .Clr_XA(clr[0]), .Add_En(add[0]), .Sub_En(sub[0]),
        .Shift_En(shf[0]), .Busy(busy[0]), .Done(done[0]), .Bit_Cnt(bc0));

    mult_seq_control #(.WIDTH(8), .SKIP_ZERO(1'b1)) u1 (
        .Clk(Clk), .Reset(rst[1]), .LoadA(lda[1]), .LoadB(ldb[1]), .Execute(exe[1]), .M(m[1]),
        .Ld_A(ld_a[1]), .Ld_B(ld_b[1]), .Clr_XA(clr[1]), .Add_En(add[1]), .Sub_En(sub[1]),
        .Shift_En(shf[1]), .Busy(busy[1]), .Done(done[1]), .Bit_Cnt(bc1));

    mult_seq_control #(.WIDTH(16), .SKIP_ZERO(1'b0)) u2 (
        .Clk(Clk), .Reset(rst[2]), .LoadA(lda[2]), .LoadB(ldb[2]), .Execute(exe[2]), .M(m[2]),
        .Ld_A(ld_a[2]), .Ld_B(ld_b[2]), .Clr_XA(clr[2]), .Add_En(add[2]), .Sub_En(sub[2]),
        .Shift_En(shf[2]), .Busy(busy[2]), .Done(done[2]), .Bit_Cnt(bc2));

    function automatic int get_bc(input int i);
        case (i)
            0:       return int'(bc0);
            1:       return int'(bc1);
            default: return int'(bc2);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: shift the B model if Shift_En was high, then settle 2 time units past the edge.
    task automatic cyc();
        logic sh;
        sh = shf[cur];
        @(posedge Clk);
        #1;
        if (sh) b = {b[31], b[31:1]};
        m[cur] = b[0];
        #1;
    endtask

    task automatic run(input int i, input logic [31:0] bv, input int drop_at,
                       output int n, output int clrs, output int adds, output int subs,
                       output int shifts, output int add_mask, output int sub_mask,
                       output int overlap, output int ldb_seen);
        int bit_idx;
        n = 0; clrs = 0; adds = 0; subs = 0; shifts = 0;
        add_mask = 0; sub_mask = 0; overlap = 0; ldb_seen = 0;
        cur = i;
        b = bv;
        m[i] = b[0];
        exe[i] = 1'b1;
        #1;
        cyc();
        while (!done[i] && n < 200) begin
            if (n == drop_at) begin
                exe[i] = 1'b0;
                #1;
            end
            bit_idx = get_bc(i);
            clrs   += int'(clr[i]);
            adds   += int'(add[i]);
            subs   += int'(sub[i]);
            shifts += int'(shf[i]);
            ldb_seen += int'(ld_b[i]);
            if (add[i] && bit_idx < 31) add_mask |= (1 << bit_idx);
            if (sub[i] && bit_idx < 31) sub_mask |= (1 << bit_idx);
            if (int'(clr[i]) + int'(add[i]) + int'(sub[i]) + int'(shf[i]) > 1) overlap++;
            cyc();
            n++;
        end
    endtask

    int n, clrs, adds, subs, shifts, amask, smask, ovl, lbs;
    int cnt_a, cnt_b;

    initial begin
        rst = 3'b111; exe = '0; lda = '0; ldb = '0; m = '0;
        cur = 0; b = '0;
        repeat (3) cyc();

        // Reset state, with the IDLE load pass-through still active
        lda[0] = 1'b1;
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_bitcnt", get_bc(0), 0);
        chk("rst_strobes", int'(clr[0] | add[0] | sub[0] | shf[0]), 0);
        chk("rst_lda_pass", ld_a[0], 1);
        lda[0] = 1'b0;
        rst = 3'b000;
        cyc();

        // W=8, M always 1
        run(0, 32'hFFFF_FFFF, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("t1_latency", n, 17);
        chk("t1_clr", clrs, 1);
        chk("t1_adds", adds, 7);
        chk("t1_subs", subs, 1);
        chk("t1_sub_bit7", smask, 32'h80);
        chk("t1_shifts", shifts, 8);
        chk("t1_onehot", ovl, 0);
        chk("t1_done", done[0], 1);
        chk("t1_bitcnt", get_bc(0), 8);

        // Execute held in HOLD, LoadB ignored there
        cnt_a = 0; cnt_b = 0; lbs = 0;
        ldb[0] = 1'b1;
        repeat (20) begin
            cyc();
            cnt_a += int'(done[0]);
            cnt_b += int'(clr[0]);
            lbs   += int'(ld_b[0]);
        end
        chk("hold_done", cnt_a, 20);
        chk("hold_no_clr", cnt_b, 0);
        chk("hold_ldb", lbs, 0);
        chk("hold_bitcnt", get_bc(0), 8);
        ldb[0] = 1'b0;
        exe[0] = 1'b0;
        cyc();
        chk("idle_done", done[0], 0);
        chk("idle_busy", busy[0], 0);
        lda[0] = 1'b1;
        #1;
        chk("idle_lda", ld_a[0], 1);
        lda[0] = 1'b0;
        #1;

        // W=8, B=0x05, LoadB held during the run
        ldb[0] = 1'b1;
        run(0, 32'h0000_0005, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        ldb[0] = 1'b0;
        chk("t2_latency", n, 17);
        chk("t2_addmask", amask, 5);
        chk("t2_subs", subs, 0);
        chk("t2_shifts", shifts, 8);
        chk("t2_busy_ldb", lbs, 0);
        exe[0] = 1'b0;
        cyc();

        // Execute dropped mid-run: run completes, HOLD lasts one cycle
        run(0, 32'hFFFF_FFFF, 4, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("drop_latency", n, 17);
        chk("drop_done", done[0], 1);
        cyc();
        chk("drop_hold_1cyc", done[0], 0);

        // Reset at cycle 6 of a run
        cur = 0;
        b = 32'hFFFF_FFFF;
        m[0] = 1'b1;
        exe[0] = 1'b1;
        #1;
        repeat (7) cyc();
        chk("mid_busy_before", busy[0], 1);
        rst[0] = 1'b1;
        #1;
        cyc();
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_bitcnt", get_bc(0), 0);
        chk("mid_rst_shift", shf[0], 0);
        rst[0] = 1'b0;
        exe[0] = 1'b0;
        cnt_a = 0;
        repeat (3) begin
            cyc();
            cnt_a += int'(shf[0]) + int'(busy[0]);
        end
        chk("mid_rst_quiet", cnt_a, 0);
        run(0, 32'hFFFF_FFFF, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("restart_clr", clrs, 1);
        chk("restart_latency", n, 17);
        chk("restart_bitcnt", get_bc(0), 8);
        exe[0] = 1'b0;
        cyc();

        // SKIP_ZERO=1
        run(1, 32'h0000_0000, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("sz0_latency", n, 9);
        chk("sz0_shifts", shifts, 8);
        chk("sz0_adds", adds + subs, 0);
        chk("sz0_onehot", ovl, 0);
        chk("sz0_bitcnt", get_bc(1), 8);
        exe[1] = 1'b0;
        cyc();
        run(1, 32'hFFFF_FFFF, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("szff_latency", n, 17);
        chk("szff_adds", adds, 7);
        chk("szff_subs", subs, 1);
        exe[1] = 1'b0;
        cyc();
        run(1, 32'h0000_0005, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("sz05_latency", n, 11);
        chk("sz05_addmask", amask, 5);
        exe[1] = 1'b0;
        cyc();

        // WIDTH=16
        run(2, 32'hFFFF_FFFF, -1, n, clrs, adds, subs, shifts, amask, smask, ovl, lbs);
        chk("w16_latency", n, 33);
        chk("w16_sub_bit15", smask, 32'h8000);
        chk("w16_adds", adds, 15);
        chk("w16_shifts", shifts, 16);
        chk("w16_bitcnt", get_bc(2), 16);
        exe[2] = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_control.md
Name: mult_seq_control

Overview:
- Parametrised sequencer for the shift-add signed multiplier datapath. It is the successor to the fixed 8-bit controller.
- Runs WIDTH add/shift iterations from a bit counter instead of unrolled states.
- Issues a subtract on the final (sign) bit for two's-complement multiplication.
- Clears the accumulator at run start and optionally skips add cycles when the multiplier bit is zero.
- Sits between the switch/button interface and the XAB register/adder datapath.

Parameters:
- WIDTH, 8, operand width; number of iterations per multiply (legal 2..32).
- SKIP_ZERO, 0, 1 = an ADD-state cycle with M=0 performs the shift directly (no separate SHIFT cycle).

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high; clock Clk
- LoadA  in  1  request to load A (multiplicand) register
- LoadB  in  1  request to load B (multiplier) register
- Execute  in  1  level-held run request; must drop before the next run
- M  in  1  current LSB of B register (multiplier bit)
- Ld_A  out  1  load enable to A register
- Ld_B  out  1  load enable to B register
- Clr_XA  out  1  clear X and accumulator A at run start
- Add_En  out  1  add multiplicand into accumulator
- Sub_En  out  1  subtract multiplicand (final-bit correction)
- Shift_En  out  1  arithmetic right shift of X:A:B
- Busy  out  1  high from CLEAR through the last SHIFT
- Done  out  1  high in HOLD
- Bit_Cnt  out  $clog2(WIDTH+1)  iterations completed

Behaviour:
- States: IDLE, CLEAR, ADD, SHIFT, HOLD. Moore outputs except Ld_A/Ld_B, which pass LoadA/LoadB combinationally in IDLE only.
- Reset (any state, including mid-run): state=IDLE, Bit_Cnt=0. All outputs 0 except the IDLE Ld_A/Ld_B pass-through.
- IDLE:
  - Ld_A=LoadA, Ld_B=LoadB.
  - Execute=1 -> CLEAR. Execute has priority over loads in the transition; loads are still passed in that cycle.
- CLEAR:
  - Clr_XA=1, Busy=1, Bit_Cnt<=0.
  - -> ADD.
- ADD:
  - Busy=1.
  - If Bit_Cnt<WIDTH-1: Add_En=M. If Bit_Cnt==WIDTH-1: Sub_En=M. Never both.
  - SKIP_ZERO=0: -> SHIFT unconditionally.
  - SKIP_ZERO=1 and M=0: Shift_En=1, Bit_Cnt<=Bit_Cnt+1. -> HOLD if Bit_Cnt==WIDTH-1, else stay in ADD.
  - SKIP_ZERO=1 and M=1: -> SHIFT.
- SHIFT:
  - Shift_En=1, Busy=1, Bit_Cnt<=Bit_Cnt+1.
  - -> HOLD if Bit_Cnt==WIDTH-1, else ADD.
- HOLD:
  - Done=1. Bit_Cnt holds WIDTH.
  - LoadA/LoadB ignored (Ld_A=Ld_B=0).
  - Execute=0 -> IDLE. Execute held -> stay; no auto-restart.
- Latency, IDLE exit to first Done cycle:
  - SKIP_ZERO=0: 1+2*WIDTH cycles (17 for WIDTH=8).
  - SKIP_ZERO=1: 1+WIDTH+popcount(multiplier bits) cycles.
- Execute dropped mid-run: ignored; run completes, HOLD lasts one cycle, then IDLE.
- Bit_Cnt never exceeds WIDTH; no wrap.
- LoadA/LoadB during Busy: ignored, no effect on the sequence.
- Exactly one of Clr_XA, Add_En, Sub_En, Shift_En may be high per cycle, except SKIP_ZERO ADD with M=0, where only Shift_En is high.

Decomposition:
- Package mult_pkg:
  - state enum type (logic [2:0]: IDLE, CLEAR, ADD, SHIFT, HOLD).
  - function cnt_w(WIDTH) returning $clog2(WIDTH+1).
- Sub-module iter_counter: WIDTH-parameterised up-counter with sync clear, increment enable and terminal flag (Bit_Cnt==WIDTH-1).

Test Plan:
- WIDTH=8, SKIP_ZERO=0, M tied 1, Execute held: Clr_XA 1 cycle; Add_En 7 cycles; Sub_En once (8th ADD); Shift_En 8 cycles; Done first at cycle 17; Bit_Cnt=8.
- Same config, M pattern from modelled B=0x05 shifting: Add_En only in iterations 0 and 2; Sub_En=0; Done at cycle 17.
- SKIP_ZERO=1, B=0x00: 8 ADD cycles each with Shift_En=1; Done at cycle 9. B=0xFF: Done at cycle 17.
- Execute held in HOLD for 20 cycles -> Done stays 1, no Clr_XA; Execute low -> IDLE next cycle; LoadA=1 -> Ld_A=1 same cycle.
- Reset asserted at cycle 6 of a run -> next cycle IDLE, Busy=0, Bit_Cnt=0, no further Shift_En; Execute high again -> clean restart with Clr_XA.
- LoadB=1 during Busy and in HOLD -> Ld_B stays 0; WIDTH=16 run -> Done at cycle 33, Sub_En at the 16th ADD.
